mod_count_checker: RTL and testbench

- Downstream consumer of the 3-bit mod-6 ripple counter output.
- Samples the count in the `clk` domain and tracks the legal sequence 0,1,…,MOD-1,0.
- Emits per-step and per-wrap pulses, counts completed wraps (tens-digit style cascade), and flags illegal values or skipped states with a sticky error.
- Sits between the counter and the display/monitor logic.

---
 rtl/mod_count_checker_if.sv | 30 +++
 rtl/mod_count_checker.sv | 129 ++++++++++++
 tb/tb_mod_count_checker.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mod_count_checker_if.sv
// Count-sample input and tracking-status bundle between the mod-N counter and the display/monitor side.
// The master drives q_in/clear; the checker (slave) returns the tracking status, pulses and wrap count.
interface mod_count_checker_if #(
    parameter int CNTW  = 3,
    parameter int WRAPW = 8
);
    logic             clear;
    logic [CNTW-1:0]  q_in;
    logic [CNTW-1:0]  cur_count;
    logic             tracking;
    logic             step_pulse;
    logic             wrap_pulse;
    logic             resync_pulse;
    logic [WRAPW-1:0] wrap_count;
    logic             wrap_ovf;
    logic             err;
    logic [1:0]       err_code;

    modport master (
        output clear, q_in,
        input  cur_count, tracking, step_pulse, wrap_pulse, resync_pulse,
               wrap_count, wrap_ovf, err, err_code
    );

    modport slave (
        input  clear, q_in,
        output cur_count, tracking, step_pulse, wrap_pulse, resync_pulse,
               wrap_count, wrap_ovf, err, err_code
    );
endinterface

// File: rtl/mod_count_checker.sv
// Follows a mod-MOD ripple count sequence, pulses on steps/wraps/resyncs, counts wraps, latches errors.
// Latency: two-flop sampler then registered outputs; no backpressure (samples every clk).
module mod_count_checker #(
    parameter int MOD    = 6,
    parameter int CNTW   = 3,
    parameter int WRAPW  = 8,
    parameter int FILTER = 1
) (
    input  logic              clk,
    input  logic              rst,
    mod_count_checker_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        ERROR = 2'd2
    } state_t;

    localparam logic [CNTW:0]   MODV = (CNTW+1)'(MOD);
    localparam logic [CNTW-1:0] LAST = CNTW'(MOD - 1);

    state_t           state, state_nx;
    logic [CNTW-1:0]  s1, s2;
    logic [CNTW-1:0]  cur, cur_nx;
    logic [WRAPW-1:0] wc, wc_nx;
    logic             ovf, ovf_nx;
    logic [1:0]       code, code_nx;
    logic             step, step_nx;
    logic             wrap, wrap_nx;
    logic             rsy, rsy_nx;
    logic             valid;
    logic             in_range;
    logic [CNTW:0]    cur_inc;

    // Ripple outputs can be mid-transition when sampled; demand two equal samples when filtering.
    assign valid    = (FILTER != 0) ? (s1 == s2) : 1'b1;
    assign in_range = ({1'b0, s2} < MODV);
    assign cur_inc  = {1'b0, cur} + (CNTW+1)'(1);

    always_comb begin
        state_nx = state;
        cur_nx   = cur;
        wc_nx    = wc;
        ovf_nx   = ovf;
        code_nx  = code;
        step_nx  = 1'b0;
        wrap_nx  = 1'b0;
        rsy_nx   = 1'b0;
        if (bus.clear) begin
            state_nx = IDLE;
            cur_nx   = '0;
            wc_nx    = '0;
            ovf_nx   = 1'b0;
            code_nx  = 2'b00;
        end else if (valid) begin
            case (state)
                IDLE: begin
                    if (in_range) begin
                        cur_nx   = s2;
                        state_nx = TRACK;
                    end else begin
                        state_nx = ERROR;
                        code_nx  = 2'b01;
                    end
                end
                TRACK: begin
                    if (s2 == cur) begin
                        state_nx = TRACK;
                    end else if (!in_range) begin
                        state_nx = ERROR;
                        code_nx  = 2'b01;
                    end else if (({1'b0, s2} == cur_inc) && (cur != LAST)) begin
                        cur_nx  = s2;
                        step_nx = 1'b1;
                    end else if (s2 == '0) begin
                        cur_nx = '0;
                        if (cur == LAST) begin
                            wrap_nx = 1'b1;
                            wc_nx   = wc + WRAPW'(1);
                            if (wc == '1) ovf_nx = 1'b1;
                        end else begin
                            rsy_nx = 1'b1;
                        end
                    end else begin
                        state_nx = ERROR;
                        code_nx  = 2'b10;
                    end
                end
                default: state_nx = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= '0;
            s2    <= '0;
            state <= IDLE;
            cur   <= '0;
            wc    <= '0;
            ovf   <= 1'b0;
            code  <= 2'b00;
            step  <= 1'b0;
            wrap  <= 1'b0;
            rsy   <= 1'b0;
        end else begin
            s1    <= bus.q_in;
            s2    <= s1;
            state <= state_nx;
            cur   <= cur_nx;
            wc    <= wc_nx;
            ovf   <= ovf_nx;
            code  <= code_nx;
            step  <= step_nx;
            wrap  <= wrap_nx;
            rsy   <= rsy_nx;
        end
    end

    assign bus.cur_count    = cur;
    assign bus.tracking     = (state == TRACK);
    assign bus.err          = (state == ERROR);
    assign bus.err_code     = code;
    assign bus.step_pulse   = step;
    assign bus.wrap_pulse   = wrap;
    assign bus.resync_pulse = rsy;
    assign bus.wrap_count   = wc;
    assign bus.wrap_ovf     = ovf;
endmodule

// File: tb/tb_mod_count_checker.sv
// Drives one count stream into a filtered (WRAPW=8) and an unfiltered (WRAPW=2) checker
// and compares both every cycle against a sequence-rule reference model.
module tb_mod_count_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mod_count_checker_if #(.CNTW(3), .WRAPW(8)) if1 ();
    mod_count_checker_if #(.CNTW(3), .WRAPW(2)) if0 ();

    mod_count_checker #(.MOD(6), .CNTW(3), .WRAPW(8), .FILTER(1)) u_f1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );
    mod_count_checker #(.MOD(6), .CNTW(3), .WRAPW(2), .FILTER(0)) u_f0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference state per instance: [0] unfiltered WRAPW=2, [1] filtered WRAPW=8.
    // m_st: 0 idle, 1 tracking, 2 error.
    int m_st[2], m_cur[2], m_wc[2], m_code[2], h1[2], h2[2];
    bit m_ovf[2], m_step[2], m_wrap[2], m_rsy[2];
    int n_step1, n_wrap1, n_rsy1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_flags(input int i);
        return {m_st[i] == 1, m_st[i] == 2, 2'(m_code[i]), m_step[i], m_wrap[i], m_rsy[i], m_ovf[i]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_cur[i] = 0; m_wc[i] = 0; m_code[i] = 0;
            h1[i] = 0; h2[i] = 0;
            m_ovf[i] = 0; m_step[i] = 0; m_wrap[i] = 0; m_rsy[i] = 0;
        end
    endtask

    // One clock edge of the sequence rules; h1/h2 hold the last two input values seen at edges.
    task automatic model_step(input int i, input int q, input bit c);
        int  v;
        bit  valid;
        v     = h2[i];
        valid = (i == 0) || (h1[i] == h2[i]);
        m_step[i] = 0; m_wrap[i] = 0; m_rsy[i] = 0;
        if (c) begin
            m_st[i] = 0; m_cur[i] = 0; m_wc[i] = 0; m_ovf[i] = 0; m_code[i] = 0;
        end else if (valid) begin
            if (m_st[i] == 0) begin
                if (v < 6) begin m_cur[i] = v; m_st[i] = 1; end
                else begin m_st[i] = 2; m_code[i] = 1; end
            end else if (m_st[i] == 1 && v != m_cur[i]) begin
                if (v >= 6) begin
                    m_st[i] = 2; m_code[i] = 1;
                end else if (v == (m_cur[i] + 1) % 6) begin
                    m_cur[i] = v;
                    if (v == 0) begin
                        m_wrap[i] = 1;
                        m_wc[i]   = (m_wc[i] + 1) % ((i == 1) ? 256 : 4);
                        if (m_wc[i] == 0) m_ovf[i] = 1;
                    end else begin
                        m_step[i] = 1;
                    end
                end else if (v == 0) begin
                    m_cur[i] = 0; m_rsy[i] = 1;
                end else begin
                    m_st[i] = 2; m_code[i] = 2;
                end
            end
        end
        h2[i] = h1[i];
        h1[i] = q;
    endtask

    task automatic check_all();
        chk("f1.cur",   32'(if1.cur_count),  32'(m_cur[1]));
        chk("f1.wcnt",  32'(if1.wrap_count), 32'(m_wc[1]));
        chk("f1.flags", 32'({if1.tracking, if1.err, if1.err_code, if1.step_pulse,
                             if1.wrap_pulse, if1.resync_pulse, if1.wrap_ovf}), 32'(model_flags(1)));
        chk("f0.cur",   32'(if0.cur_count),  32'(m_cur[0]));
        chk("f0.wcnt",  32'(if0.wrap_count), 32'(m_wc[0]));
        chk("f0.flags", 32'({if0.tracking, if0.err, if0.err_code, if0.step_pulse,
                             if0.wrap_pulse, if0.resync_pulse, if0.wrap_ovf}), 32'(model_flags(0)));
        n_step1 += int'(if1.step_pulse);
        n_wrap1 += int'(if1.wrap_pulse);
        n_rsy1  += int'(if1.resync_pulse);
    endtask

    // Called at a negedge: present inputs for the coming edge, advance the model, check after it.
    task automatic cyc(input int q, input bit c);
        if1.q_in = 3'(q); if0.q_in = 3'(q);
        if1.clear = c;    if0.clear = c;
        model_step(0, q, c);
        model_step(1, q, c);
        @(negedge clk);
        check_all();
    endtask

    task automatic hold(input int q, input int n);
        for (int k = 0; k < n; k++) cyc(q, 1'b0);
    endtask

    task automatic clear_counts();
        n_step1 = 0; n_wrap1 = 0; n_rsy1 = 0;
    endtask

    initial begin
        int last, nxt, len;
        bit clr;
        if1.q_in = '0; if0.q_in = '0; if1.clear = 1'b0; if0.clear = 1'b0;
        model_reset();
        clear_counts();
        repeat (2) @(negedge clk);
        chk("reset.f1", 32'({if1.cur_count, if1.wrap_count, if1.tracking, if1.err, if1.err_code,
                             if1.step_pulse, if1.wrap_pulse, if1.resync_pulse, if1.wrap_ovf}), 32'd0);
        rst = 1'b0;
        hold(0, 3);

        // Legal cycle, each value held two cycles.
        clear_counts();
        for (int v = 0; v < 6; v++) hold(v, 2);
        hold(0, 4);
        chk("legal.steps", 32'(n_step1), 32'd5);
        chk("legal.wraps", 32'(n_wrap1), 32'd1);
        chk("legal.wcnt",  32'(if1.wrap_count), 32'd1);
        chk("legal.cur",   32'(if1.cur_count), 32'd0);

        // Resync: early return to zero, then continue stepping.
        clear_counts();
        hold(1, 2); hold(2, 2); hold(3, 2); hold(0, 2); hold(1, 3);
        chk("resync.count", 32'(n_rsy1), 32'd1);
        chk("resync.wcnt",  32'(if1.wrap_count), 32'd1);
        chk("resync.cur",   32'(if1.cur_count), 32'd1);

        // Skip error freezes, ignores input, releases on clear.
        hold(2, 2); hold(3, 2); hold(5, 3); hold(0, 3);
        chk("skip.code", 32'(if1.err_code), 32'd2);
        chk("skip.cur",  32'(if1.cur_count), 32'd3);
        cyc(0, 1'b1);
        chk("skip.clr",  32'({if1.err, if1.tracking}), 32'd0);
        hold(0, 3);

        // Range errors from TRACK and from IDLE.
        hold(1, 2); hold(2, 2); hold(3, 2); hold(4, 2); hold(6, 3);
        chk("range.trk", 32'(if1.err_code), 32'd1);
        cyc(7, 1'b1);
        hold(7, 4);
        chk("range.idle", 32'({if1.tracking, if1.err, if1.err_code}), 32'b0101);

        // Asynchronous reset between edges mid-count.
        cyc(0, 1'b1);
        hold(0, 3); hold(1, 2); hold(2, 2);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst.f1", 32'({if1.cur_count, if1.wrap_count, if1.tracking, if1.err, if1.err_code,
                            if1.step_pulse, if1.wrap_pulse, if1.resync_pulse, if1.wrap_ovf}), 32'd0);
        chk("arst.f0", 32'({if0.cur_count, if0.wrap_count, if0.tracking, if0.err, if0.err_code,
                            if0.step_pulse, if0.wrap_pulse, if0.resync_pulse, if0.wrap_ovf}), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        hold(0, 3);
        chk("arst.track", 32'(if1.tracking), 32'd1);

        // Four fast wraps on the unfiltered 2-bit wrap counter, then clear on the fifth.
        for (int k = 0; k < 4; k++)
            for (int v = 0; v < 6; v++) cyc(v, 1'b0);
        hold(0, 3);
        chk("ovf.wcnt", 32'(if0.wrap_count), 32'd0);
        chk("ovf.flag", 32'(if0.wrap_ovf), 32'd1);
        for (int v = 1; v < 6; v++) cyc(v, 1'b0);
        cyc(0, 1'b0); cyc(0, 1'b0); cyc(0, 1'b1);
        chk("ovfclr.f0", 32'({if0.wrap_count, if0.wrap_ovf, if0.wrap_pulse}), 32'd0);
        hold(0, 3);

        // Randomized mostly-legal stream with glitches, jumps and occasional clears.
        last = 0;
        for (int s = 0; s < 250; s++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 7)       nxt = (last + 1) % 6;
            else if (r < 8)  nxt = 0;
            else             nxt = $urandom_range(0, 7);
            clr = ($urandom_range(0, 24) == 0);
            len = $urandom_range(1, 3);
            cyc(nxt, clr);
            if (len > 1) hold(nxt, len - 1);
            last = nxt;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
